sc_gate_tree: RTL and testbench

- Parametrised, pipelined successor to the cascading stochastic gate.
- Reduces N stochastic bitstreams per channel, for C independent channels, with a run-time selectable operator: AND, OR, XOR or XNOR.
- A per-channel window counter turns the output bitstream into a binary probability estimate.
- Sits between stochastic neuron layers and the readout/debug logic of the SC network.

---
 rtl/sc_gate_tree.sv | 161 ++++++++++++++++
 tb/tb_sc_gate_tree.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sc_gate_tree.sv
// rtl/sc_gate_tree.sv - pipelined N-input stochastic gate tree with per-channel window counters
module sc_gate_tree #(
    parameter int N = 3,
    parameter int C = 1,
    parameter int W = 8
) (
    input  logic                 CLK,
    input  logic                 INIT_N,
    input  logic                 EN,
    input  logic [1:0]           MODE,
    input  logic                 CLR,
    input  logic [C*N-1:0]       IN,
    output logic [C-1:0]         OUT,
    output logic                 VLD,
    output logic [C*(W+1)-1:0]   CNT,
    output logic                 DONE
);

    localparam int L = $clog2(N);

    // Element count per channel after l halvings (odd tails carried through).
    function automatic int lvl_cnt(input int l);
        int n;
        n = N;
        for (int i = 0; i < l; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // XNOR shares the XOR tree; the inversion happens only at the last level.
    function automatic logic gate2(input logic a, input logic b, input logic [1:0] m);
        case (m)
            2'd0:    return a & b;
            2'd1:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Mode and valid travel alongside their sample, one register per level.
    logic [1:0] mode_lv [0:L-1];
    logic       vld_lv  [0:L];

    assign mode_lv[0] = MODE;
    assign vld_lv[0]  = EN;

    for (genvar l = 0; l <= L; l++) begin : g_lv
        localparam int K = lvl_cnt(l);
        logic [C*K-1:0] d;

        if (l == 0) begin : g_src
            assign d = IN;
        end else begin : g_stage
            localparam int KP = lvl_cnt(l - 1);
            logic [C*KP-1:0] p;
            logic [C*K-1:0]  t;
            logic [C*K-1:0]  d_d;
            logic [C*K-1:0]  d_q;
            logic            v_q;

            assign p = g_lv[l-1].d;

            // Pairwise reduction of the previous level; an unpaired tail passes through.
            always_comb begin
                t = '0;
                for (int c = 0; c < C; c++) begin
                    for (int k = 0; k < K; k++) begin
                        int ia;
                        int ib;
                        ia = c * KP + 2 * k;
                        ib = (2 * k + 1 < KP) ? ia + 1 : ia;
                        if (2 * k + 1 < KP)
                            t[c*K+k] = gate2(p[ia], p[ib], mode_lv[l-1]);
                        else
                            t[c*K+k] = p[ia];
                    end
                end
            end

            if (l == L) begin : g_last
                // Bubbles leave the tree as zero; XNOR inverts the final XOR result.
                assign d_d = !vld_lv[l-1] ? '0 :
                             (mode_lv[l-1] == 2'd3) ? ~t : t;
            end else begin : g_mid
                logic [1:0] m_q;
                assign d_d = t;

                // Carry the sample's own mode to the next level.
                always_ff @(posedge CLK or negedge INIT_N) begin
                    if (!INIT_N) m_q <= 2'd0;
                    else         m_q <= mode_lv[l-1];
                end

                assign mode_lv[l] = m_q;
            end

            // Level register for data and sample valid.
            always_ff @(posedge CLK or negedge INIT_N) begin
                if (!INIT_N) begin
                    d_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    d_q <= d_d;
                    v_q <= vld_lv[l-1];
                end
            end

            assign d         = d_q;
            assign vld_lv[l] = v_q;
        end
    end

    assign OUT = g_lv[L].d;
    assign VLD = vld_lv[L];

    logic [W-1:0]       pos_q,  pos_d;
    logic [C*(W+1)-1:0] run_q,  run_d;
    logic [C*(W+1)-1:0] cnt_q,  cnt_d;
    logic               done_q, done_d;

    // Window accounting: clear wins over completion; bubbles change nothing.
    always_comb begin
        pos_d  = pos_q;
        run_d  = run_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (CLR) begin
            pos_d = '0;
            run_d = '0;
        end else if (VLD) begin
            if (pos_q == {W{1'b1}}) begin
                for (int c = 0; c < C; c++)
                    cnt_d[c*(W+1) +: W+1] = run_q[c*(W+1) +: W+1] + {{W{1'b0}}, OUT[c]};
                run_d  = '0;
                pos_d  = '0;
                done_d = 1'b1;
            end else begin
                for (int c = 0; c < C; c++)
                    run_d[c*(W+1) +: W+1] = run_q[c*(W+1) +: W+1] + {{W{1'b0}}, OUT[c]};
                pos_d = pos_q + 1'b1;
            end
        end
    end

    // Window state registers.
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            pos_q  <= '0;
            run_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign CNT  = cnt_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_sc_gate_tree.sv
// tb/tb_sc_gate_tree.sv - scoreboard bench for sc_gate_tree (N=4, C=2, W=4)
module tb_sc_gate_tree;

    localparam int N = 4;
    localparam int C = 2;
    localparam int W = 4;
    localparam int L = 2;

    logic       CLK = 1'b0;
    logic       INIT_N = 1'b0;
    logic       EN = 1'b0;
    logic       CLR = 1'b0;
    logic [1:0] MODE = 2'd0;
    logic [7:0] IN = 8'h00;
    wire  [1:0] OUT;
    wire        VLD;
    wire  [9:0] CNT;
    wire        DONE;

    sc_gate_tree #(.N(N), .C(C), .W(W)) dut (
        .CLK(CLK), .INIT_N(INIT_N), .EN(EN), .MODE(MODE), .CLR(CLR),
        .IN(IN), .OUT(OUT), .VLD(VLD), .CNT(CNT), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad = 0;
    logic [2:0] exq[$];
    logic [2:0] prev = 3'b000;
    int         m_pos = 0;
    int         m_run[2] = '{0, 0};
    int         m_cnt[2] = '{0, 0};
    logic       m_done = 1'b0;
    int         done_seen = 0;
    logic [1:0] mode_exp[4] = '{2'b00, 2'b11, 2'b11, 2'b00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic red(input logic [1:0] m, input logic [3:0] x);
        case (m)
            2'd0:    return &x;
            2'd1:    return |x;
            2'd2:    return ^x;
            default: return ~^x;
        endcase
    endfunction

    task automatic step(input logic en, input logic [1:0] mode, input logic [7:0] in, input logic clr);
        logic [2:0] e;
        EN = en; MODE = mode; IN = in; CLR = clr;
        e = en ? {1'b1, red(mode, in[7:4]), red(mode, in[3:0])} : 3'b000;
        exq.push_back(e);
        @(posedge CLK);
        #1;
        m_done = 1'b0;
        if (clr) begin
            m_pos = 0;
            for (int c = 0; c < C; c++) m_run[c] = 0;
        end else if (prev[2]) begin
            if (m_pos == 15) begin
                for (int c = 0; c < C; c++) begin
                    m_cnt[c] = m_run[c] + int'(prev[c]);
                    m_run[c] = 0;
                end
                m_pos  = 0;
                m_done = 1'b1;
            end else begin
                for (int c = 0; c < C; c++) m_run[c] += int'(prev[c]);
                m_pos++;
            end
        end
        check("done", 32'(DONE), 32'(m_done));
        check("cnt0", 32'(CNT[4:0]), 32'(m_cnt[0]));
        check("cnt1", 32'(CNT[9:5]), 32'(m_cnt[1]));
        if (DONE) done_seen++;
        if (exq.size() == L) prev = exq.pop_front();
        else                 prev = 3'b000;
        check("vld", 32'(VLD), 32'(prev[2]));
        check("out", 32'(OUT), 32'(prev[1:0]));
    endtask

    task automatic async_reset();
        INIT_N = 1'b0;
        #1;
        check("arst_cnt", 32'(CNT), 32'd0);
        check("arst_done", 32'(DONE), 32'd0);
        check("arst_vld", 32'(VLD), 32'd0);
        check("arst_out", 32'(OUT), 32'd0);
        INIT_N = 1'b1;
        exq.delete();
        prev  = 3'b000;
        m_pos = 0;
        for (int c = 0; c < C; c++) begin
            m_run[c] = 0;
            m_cnt[c] = 0;
        end
    endtask

    initial begin
        logic cl;
        // Reset held with active-looking inputs
        IN = 8'hFF; EN = 1'b1; MODE = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("rst_vld", 32'(VLD), 32'd0);
            check("rst_out", 32'(OUT), 32'd0);
            check("rst_cnt", 32'(CNT), 32'd0);
            check("rst_done", 32'(DONE), 32'd0);
        end
        INIT_N = 1'b1;

        // Latency: first valid sample visible after the second edge
        step(1'b1, 2'd0, 8'hFF, 1'b0);
        check("lat1_vld", 32'(VLD), 32'd0);
        step(1'b1, 2'd0, 8'hFF, 1'b0);
        check("lat2_vld", 32'(VLD), 32'd1);
        check("lat2_out", 32'(OUT), 32'd3);

        // Mode sweep on 0111 per channel
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 2'(m), 8'h77, 1'b0);
            check("mode_out", 32'(OUT), 32'(mode_exp[m]));
        end
        for (int i = 0; i < 8; i++) step(1'b1, 2'(i % 4), 8'h77, 1'b0);

        // Bubbles
        step(1'b1, 2'd1, 8'hFF, 1'b0);
        step(1'b0, 2'd1, 8'hFF, 1'b0);
        step(1'b1, 2'd1, 8'hFF, 1'b0);
        step(1'b0, 2'd1, 8'hFF, 1'b0);
        step(1'b0, 2'd1, 8'hFF, 1'b0);

        // Window count: ch0 all ones, ch1 alternating
        step(1'b0, 2'd0, 8'h00, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 2'd0, {((i % 2) != 0) ? 4'h0 : 4'hF, 4'hF}, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        check("win1_done_cnt", 32'(done_seen), 32'd1);
        check("win1_cnt", 32'(CNT), 32'({5'd8, 5'd16}));

        // Next window starts from zero: ch0 alternating, ch1 all ones
        done_seen = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 2'd0, {4'hF, ((i % 2) != 0) ? 4'h0 : 4'hF}, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        check("win2_done_cnt", 32'(done_seen), 32'd1);
        check("win2_cnt", 32'(CNT), 32'({5'd16, 5'd8}));

        // CLR on the completing valid cycle
        done_seen = 0;
        cl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cl = (m_pos == 15) && prev[2];
            step(1'b1, 2'd0, 8'hFF, cl);
            if (cl) break;
        end
        check("clr_reached", 32'(cl), 32'd1);
        check("clr_no_done", 32'(done_seen), 32'd0);
        check("clr_cnt_hold", 32'(CNT), 32'({5'd16, 5'd8}));
        done_seen = 0;
        for (int i = 0; i < 15; i++) step(1'b1, 2'd0, 8'hFF, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        check("clr_next_done", 32'(done_seen), 32'd1);
        check("clr_next_cnt", 32'(CNT), 32'({5'd16, 5'd16}));

        // Asynchronous reset partway through a window
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 8'hFF, 1'b0);
        async_reset();
        done_seen = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 2'd0, 8'hFF, 1'b0);
        check("arst_early_done", 32'(done_seen), 32'd0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        check("arst_done_cnt", 32'(done_seen), 32'd1);
        check("arst_cnt_after", 32'(CNT), 32'({5'd16, 5'd16}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
